// File: rtl/tx_frame_sender.sv
// tx_frame_sender
// Streams a response frame byte-by-byte into a byte UART. On tx_start the
// frame is latched: the 5-byte exception frame when exception is nonzero,
// otherwise the 8-byte write-echo frame. Bytes leave MSB-first, and each new
// byte waits for the UART to accept and finish the previous one.
//
// Build option: define TX_FRAME_GAP_EN to insert GAP_CYCLES idle clocks of
// line silence after the last byte, before frame_done. When it is undefined,
// no gap counter is built.
//
// Ports:
//   clk_in          rising-edge system clock
//   rst_n_in        asynchronous active-low reset
//   tx_start        one-cycle pulse, frame ready (ignored unless idle)
//   exception       nonzero selects the exception frame
//   exception_seq   5-byte exception frame, first byte in [39:32]
//   code06_response 8-byte write-echo frame, first byte in [63:56]
//   uart_busy       UART shifting a byte
//   uart_data       byte to transmit, held between strobes
//   uart_wr         one-cycle write strobe to the UART
//   frame_busy      frame in progress
//   frame_done      one-cycle pulse at frame completion
module tx_frame_sender #(
  parameter logic [31:0] GAP_CYCLES = 32'd200508
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        tx_start,
  input  logic [7:0]  exception,
  input  logic [39:0] exception_seq,
  input  logic [63:0] code06_response,
  input  logic        uart_busy,
  output logic [7:0]  uart_data,
  output logic        uart_wr,
  output logic        frame_busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_IDLE = 3'd3,
    S_GAP       = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  state_e      state_q,      state_d;
  logic [63:0] shift_q,      shift_d;
  logic [3:0]  len_q,        len_d;
  logic [3:0]  cnt_q,        cnt_d;
  logic [7:0]  uart_data_q,  uart_data_d;
  logic        uart_wr_q,    uart_wr_d;
  logic        frame_busy_q, frame_busy_d;
  logic        frame_done_q, frame_done_d;
`ifdef TX_FRAME_GAP_EN
  logic [31:0] gap_cnt_q,    gap_cnt_d;
`endif

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    uart_data_d  = uart_data_q;
    uart_wr_d    = 1'b0;
    frame_busy_d = frame_busy_q;
    frame_done_d = 1'b0;
`ifdef TX_FRAME_GAP_EN
    gap_cnt_d    = gap_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          if (exception != 8'h00) begin
            shift_d = {exception_seq, 24'h000000};
            len_d   = 4'd5;
          end else begin
            shift_d = code06_response;
            len_d   = 4'd8;
          end
          cnt_d        = 4'd0;
          frame_busy_d = 1'b1;
          state_d      = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        uart_data_d = shift_q[63:56];
        uart_wr_d   = 1'b1;
        state_d     = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // The UART raises busy the cycle after the strobe; wait for it so the
        // following idle check cannot see the pre-strobe idle level.
        if (uart_busy) begin
          state_d = S_WAIT_IDLE;
        end else begin
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_IDLE: begin
        if (!uart_busy) begin
          shift_d = {shift_q[55:0], 8'h00};
          cnt_d   = cnt_q + 4'd1;
          if ((cnt_q + 4'd1) == len_q) begin
            state_d = S_GAP;
`ifdef TX_FRAME_GAP_EN
            gap_cnt_d = 32'd0;
`endif
          end else begin
            state_d = S_SEND;
          end
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      S_GAP: begin
`ifdef TX_FRAME_GAP_EN
        // Entry cycle counts as gap clock 0; done lands GAP_CYCLES+1 cycles
        // after the final busy fall.
        if ((gap_cnt_q + 32'd1) >= GAP_CYCLES) begin
          gap_cnt_d    = 32'd0;
          frame_done_d = 1'b1;
          frame_busy_d = 1'b0;
          state_d      = S_DONE;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
          state_d   = S_GAP;
        end
`else
        frame_done_d = 1'b1;
        frame_busy_d = 1'b0;
        state_d      = S_DONE;
`endif
      end
      S_DONE: begin
        // frame_done is high during this state; tx_start is not looked at.
        frame_busy_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d      = S_IDLE;
        shift_d      = 64'h0;
        len_d        = 4'd0;
        cnt_d        = 4'd0;
        uart_data_d  = 8'h00;
        uart_wr_d    = 1'b0;
        frame_busy_d = 1'b0;
        frame_done_d = 1'b0;
`ifdef TX_FRAME_GAP_EN
        gap_cnt_d    = 32'd0;
`endif
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      shift_q      <= 64'h0;
      len_q        <= 4'd0;
      cnt_q        <= 4'd0;
      uart_data_q  <= 8'h00;
      uart_wr_q    <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef TX_FRAME_GAP_EN
      gap_cnt_q    <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      uart_data_q  <= uart_data_d;
      uart_wr_q    <= uart_wr_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
`ifdef TX_FRAME_GAP_EN
      gap_cnt_q    <= gap_cnt_d;
`endif
    end
  end

  assign uart_data  = uart_data_q;
  assign uart_wr    = uart_wr_q;
  assign frame_busy = frame_busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tx_frame_sender.sv
// Bench for tx_frame_sender: a 20-cycle UART busy model, a byte scoreboard
// filled when a frame is started and drained on every uart_wr, and a linear
// sequence of directed frames (exception, write echo, ignored restart, reset
// mid-frame).
module tb_tx_frame_sender;

  localparam logic [31:0] GAP = 32'd10;
`ifdef TX_FRAME_GAP_EN
  localparam int unsigned EXP_DONE_LAT = 11;
`else
  localparam int unsigned EXP_DONE_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic [7:0]  exception = 8'h00;
  logic [39:0] exception_seq = 40'h0;
  logic [63:0] code06_response = 64'h0;
  logic        uart_busy;
  logic [7:0]  uart_data;
  logic        uart_wr;
  logic        frame_busy;
  logic        frame_done;

  int unsigned n_assert = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned strobe_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned last_fall_cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned first_wr_cyc = 0;
  bit          arm_first = 1'b0;
  logic [7:0]  exp_q[$];
  logic [4:0]  bcnt;

  tx_frame_sender #(.GAP_CYCLES(GAP)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .tx_start       (tx_start),
    .exception      (exception),
    .exception_seq  (exception_seq),
    .code06_response(code06_response),
    .uart_busy      (uart_busy),
    .uart_data      (uart_data),
    .uart_wr        (uart_wr),
    .frame_busy     (frame_busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy rises the cycle after uart_wr and stays high 20 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_busy <= 1'b0;
      bcnt      <= 5'd0;
    end else if (uart_wr) begin
      uart_busy <= 1'b1;
      bcnt      <= 5'd20;
    end else if (bcnt > 5'd1) begin
      bcnt <= bcnt - 5'd1;
    end else if (bcnt == 5'd1) begin
      bcnt      <= 5'd0;
      uart_busy <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard on strobes, busy-fall and frame_done bookkeeping.
  initial begin : monitor
    logic prev_busy;
    logic [7:0] e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_wr === 1'b1) begin
        strobe_cnt++;
        if (arm_first) begin
          first_wr_cyc = cyc;
          arm_first = 1'b0;
        end
        chk("wr_while_busy", {63'd0, uart_busy}, 64'd0);
        chk("sb_nonempty", {63'd0, (exp_q.size() != 0)}, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("byte", {56'd0, uart_data}, {56'd0, e});
        end
      end
      if (prev_busy && !uart_busy) last_fall_cyc = cyc;
      prev_busy = uart_busy;
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  task automatic start_frame(input logic [7:0] exc, input logic [39:0] seq, input logic [63:0] c06);
    @(negedge clk);
    exception = exc;
    exception_seq = seq;
    code06_response = c06;
    tx_start = 1'b1;
    start_cyc = cyc;
    arm_first = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("frame_busy_set", {63'd0, frame_busy}, 64'd1);
  endtask

  task automatic push_bytes(input logic [63:0] frame, input int n);
    logic [63:0] f;
    f = frame;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(f[63:56]);
      f = f << 8;
    end
  endtask

  // Returns #1 after the negedge where frame_done is seen high.
  task automatic wait_done();
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("done_seen", {63'd0, frame_done}, 64'd1);
  endtask

  task automatic wait_strobes(input int unsigned target);
    int k;
    k = 0;
    while (strobe_cnt < target && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("strobes_reached", {63'd0, (strobe_cnt >= target)}, 64'd1);
  endtask

  localparam logic [39:0] EXC_SEQ = 40'h01_86_02_C3_A1;
  localparam logic [63:0] C06     = 64'h01_06_00_01_00_03_98_0B;

  initial begin : stim
    int unsigned s0;
    int unsigned d0;
    int unsigned lat;
    repeat (3) @(negedge clk);
    chk("rst_uart_data", {56'd0, uart_data}, 64'd0);
    chk("rst_uart_wr", {63'd0, uart_wr}, 64'd0);
    chk("rst_frame_busy", {63'd0, frame_busy}, 64'd0);
    chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Exception frame: five bytes.
    s0 = strobe_cnt;
    d0 = done_cnt;
    push_bytes({EXC_SEQ, 24'h0}, 5);
    start_frame(8'h02, EXC_SEQ, C06);
    wait_done();
    lat = cyc - last_fall_cyc;
    chk("exc_done_latency", 64'(lat), 64'(EXP_DONE_LAT));
    chk("exc_first_wr_lat", 64'(first_wr_cyc - start_cyc), 64'd2);
    repeat (30) @(negedge clk);
    chk("exc_strobes", 64'(strobe_cnt - s0), 64'd5);
    chk("exc_done_once", 64'(done_cnt - d0), 64'd1);
    chk("exc_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("exc_busy_clear", {63'd0, frame_busy}, 64'd0);
    chk("data_held", {56'd0, uart_data}, 64'h0A1);

    // Write-echo frame, second tx_start during byte 3, tx_start in DONE cycle.
    s0 = strobe_cnt;
    d0 = done_cnt;
    push_bytes(C06, 8);
    start_frame(8'h00, EXC_SEQ, C06);
    wait_strobes(s0 + 3);
    exception = 8'h07;
    code06_response = 64'hFFEE_DDCC_BBAA_9988;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done();
    lat = cyc - last_fall_cyc;
    chk("c06_done_latency", 64'(lat), 64'(EXP_DONE_LAT));
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("c06_first_wr_lat", 64'(first_wr_cyc - start_cyc), 64'd2);
    repeat (40) @(negedge clk);
    chk("c06_strobes", 64'(strobe_cnt - s0), 64'd8);
    chk("c06_done_once", 64'(done_cnt - d0), 64'd1);
    chk("c06_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("done_cycle_start_ignored", {63'd0, frame_busy}, 64'd0);

    // Reset during byte 4, then a full frame from byte 1.
    s0 = strobe_cnt;
    push_bytes(C06, 8);
    start_frame(8'h00, EXC_SEQ, C06);
    wait_strobes(s0 + 4);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_uart_data", {56'd0, uart_data}, 64'd0);
    chk("mid_rst_uart_wr", {63'd0, uart_wr}, 64'd0);
    chk("mid_rst_frame_busy", {63'd0, frame_busy}, 64'd0);
    chk("mid_rst_frame_done", {63'd0, frame_done}, 64'd0);
    exp_q.delete();
    s0 = strobe_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_rst_no_strobes", 64'(strobe_cnt - s0), 64'd0);
    chk("post_rst_idle", {63'd0, frame_busy}, 64'd0);

    d0 = done_cnt;
    push_bytes(C06, 8);
    start_frame(8'h00, EXC_SEQ, C06);
    wait_done();
    repeat (30) @(negedge clk);
    chk("rerun_strobes", 64'(strobe_cnt - s0), 64'd8);
    chk("rerun_done_once", 64'(done_cnt - d0), 64'd1);
    chk("rerun_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
